// File: rtl/z80_io_decoder_if.sv
// z80_io_decoder_if: Z80 I/O bus and device-side signals of the I/O decoder
//   slave  modport (decoder): Z80 inputs i_addr/i_iorq_n/i_rd_n/i_wr_n/i_m1_n,
//                             i_wait from waitstate generator, i_timeout_clr;
//                             outputs o_device/o_hit/o_cs_n/o_rd_stb/o_wr_stb/
//                             o_addr/o_busy/o_timeout (+ o_inta when
//                             Z80_IO_DECODER_INTACK_EN is defined)
//   master modport (bus side): the same signals with directions reversed
interface z80_io_decoder_if;
    logic [7:0] i_addr;
    logic       i_iorq_n;
    logic       i_rd_n;
    logic       i_wr_n;
    logic       i_m1_n;
    logic       i_wait;
    logic       i_timeout_clr;
    logic [1:0] o_device;
    logic       o_hit;
    logic [3:0] o_cs_n;
    logic       o_rd_stb;
    logic       o_wr_stb;
    logic [7:0] o_addr;
    logic       o_busy;
    logic       o_timeout;
`ifdef Z80_IO_DECODER_INTACK_EN
    logic       o_inta;
    modport slave (
        input  i_addr, i_iorq_n, i_rd_n, i_wr_n, i_m1_n, i_wait, i_timeout_clr,
        output o_device, o_hit, o_cs_n, o_rd_stb, o_wr_stb, o_addr, o_busy, o_timeout, o_inta
    );
    modport master (
        output i_addr, i_iorq_n, i_rd_n, i_wr_n, i_m1_n, i_wait, i_timeout_clr,
        input  o_device, o_hit, o_cs_n, o_rd_stb, o_wr_stb, o_addr, o_busy, o_timeout, o_inta
    );
`else
    modport slave (
        input  i_addr, i_iorq_n, i_rd_n, i_wr_n, i_m1_n, i_wait, i_timeout_clr,
        output o_device, o_hit, o_cs_n, o_rd_stb, o_wr_stb, o_addr, o_busy, o_timeout
    );
    modport master (
        output i_addr, i_iorq_n, i_rd_n, i_wr_n, i_m1_n, i_wait, i_timeout_clr,
        input  o_device, o_hit, o_cs_n, o_rd_stb, o_wr_stb, o_addr, o_busy, o_timeout
    );
`endif
endinterface

// File: rtl/z80_io_decoder.sv
// z80_io_decoder: decodes Z80 IORQ cycles into four device slots and issues one
// read/write strobe per cycle after WAIT is released; sticky stuck-cycle flag.
//   i_clk, i_reset (async, active-high)
//   bus: z80_io_decoder_if.slave carrying the Z80 bus inputs, i_wait,
//        i_timeout_clr and the decoder outputs (slot, hit, chip selects,
//        strobes, latched address, busy, timeout)
// Optional: define Z80_IO_DECODER_INTACK_EN to track interrupt-acknowledge
// cycles in an INTA state with an o_inta output; otherwise they are ignored.
module z80_io_decoder #(
    parameter logic [7:0]  DEV0_BASE = 8'h00,
    parameter logic [7:0]  DEV1_BASE = 8'h10,
    parameter logic [7:0]  DEV2_BASE = 8'h20,
    parameter logic [7:0]  DEV3_BASE = 8'h30,
    parameter logic [7:0]  DEV_MASK  = 8'hF0,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                i_clk,
    input  logic                i_reset,
    z80_io_decoder_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE, INTA} state_t;

    state_t     state;
    logic [7:0] addr_q;
    logic [1:0] dev_q;
    logic       hit_q;
    logic       wr_q;
    logic [3:0] cs_n_q;
    logic       rd_stb_q;
    logic       wr_stb_q;
    logic       busy_q;
    logic       timeout_q;
    logic [7:0] cnt;
    logic [3:0] m;
    logic [1:0] dec_dev;
    logic       dec_hit;
    logic       to_set;
    logic       xfer;

    assign m[0] = (bus.i_addr & DEV_MASK) == (DEV0_BASE & DEV_MASK);
    assign m[1] = (bus.i_addr & DEV_MASK) == (DEV1_BASE & DEV_MASK);
    assign m[2] = (bus.i_addr & DEV_MASK) == (DEV2_BASE & DEV_MASK);
    assign m[3] = (bus.i_addr & DEV_MASK) == (DEV3_BASE & DEV_MASK);
    // priority chain: lowest slot wins when bases overlap
    assign dec_dev = m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : m[3] ? 2'd3 : 2'd0;
    assign dec_hit = |m;

    // counter value after this clock reaches TIMEOUT (saturating)
    assign to_set = (state != IDLE) && (cnt >= 8'(TIMEOUT - 1));
    // data phase: WAIT released and the line matching the latched direction is low
    assign xfer   = !bus.i_wait && (wr_q ? !bus.i_wr_n : !bus.i_rd_n);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= IDLE;
            addr_q    <= 8'h00;
            dev_q     <= 2'd0;
            hit_q     <= 1'b0;
            wr_q      <= 1'b0;
            cs_n_q    <= 4'hF;
            rd_stb_q  <= 1'b0;
            wr_stb_q  <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt       <= 8'd0;
`ifdef Z80_IO_DECODER_INTACK_EN
            bus.o_inta <= 1'b0;
`endif
        end else begin
            rd_stb_q  <= 1'b0;
            wr_stb_q  <= 1'b0;
            cnt       <= state == IDLE ? 8'd0 : (cnt >= 8'(TIMEOUT) ? cnt : cnt + 8'd1);
            timeout_q <= to_set | (timeout_q & !bus.i_timeout_clr);
            case (state)
                IDLE: begin
                    if (!bus.i_iorq_n && bus.i_m1_n) begin
                        state  <= ACTIVE;
                        addr_q <= bus.i_addr;
                        dev_q  <= dec_dev;
                        hit_q  <= dec_hit;
                        wr_q   <= !bus.i_wr_n;
                        busy_q <= 1'b1;
                        cs_n_q <= dec_hit ? ~(4'b0001 << dec_dev) : 4'hF;
                    end
`ifdef Z80_IO_DECODER_INTACK_EN
                    else if (!bus.i_iorq_n) begin
                        state      <= INTA;
                        busy_q     <= 1'b1;
                        bus.o_inta <= 1'b1;
                    end
`endif
                end
                ACTIVE: begin
                    if (bus.i_iorq_n) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        cs_n_q <= 4'hF;
                    end else if (xfer) begin
                        state    <= DONE;
                        rd_stb_q <= hit_q && !wr_q;
                        wr_stb_q <= hit_q && wr_q;
                    end
                end
                DONE: begin
                    if (bus.i_iorq_n) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        cs_n_q <= 4'hF;
                    end
                end
                INTA: begin
                    if (bus.i_iorq_n) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
`ifdef Z80_IO_DECODER_INTACK_EN
                        bus.o_inta <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // slot index is combinational in IDLE so the waitstate generator sees it
    // in the very first IORQ-low clock
    assign bus.o_device  = state == IDLE ? dec_dev : dev_q;
    assign bus.o_hit     = state == IDLE ? dec_hit : hit_q;
    assign bus.o_cs_n    = cs_n_q;
    assign bus.o_rd_stb  = rd_stb_q;
    assign bus.o_wr_stb  = wr_stb_q;
    assign bus.o_addr    = addr_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_timeout = timeout_q;
endmodule

// File: doc/z80_io_decoder.md
Name: z80_io_decoder

Overview:
- Front end of the Z80 I/O path.
- Watches IORQ cycles, decodes the 8-bit port address into one of four device slots, and drives the slot index to the waitstate generator.
- After the waitstate generator releases WAIT, issues exactly one read or write strobe per I/O cycle to the selected device.
- Also provides a stuck-cycle timeout flag for debug.

Parameters:
- DEV0_BASE, 8'h00, port base of slot 0
- DEV1_BASE, 8'h10, port base of slot 1
- DEV2_BASE, 8'h20, port base of slot 2
- DEV3_BASE, 8'h30, port base of slot 3
- DEV_MASK, 8'hF0, address bits compared against each base
- TIMEOUT, 64, clocks an I/O cycle may stay active before o_timeout sets (2..255)

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous reset, active-high
- i_addr  in  8  Z80 A[7:0]
- i_iorq_n  in  1  Z80 IORQ, active-low
- i_rd_n  in  1  Z80 RD, active-low
- i_wr_n  in  1  Z80 WR, active-low
- i_m1_n  in  1  Z80 M1, active-low
- i_wait  in  1  active-high wait from the waitstate generator
- i_timeout_clr  in  1  clears o_timeout
- o_device  out  2  slot index to the waitstate generator
- o_hit  out  1  current/latched address matches a slot
- o_cs_n  out  4  per-slot chip select, active-low
- o_rd_stb  out  1  one-clock read strobe
- o_wr_stb  out  1  one-clock write strobe
- o_addr  out  8  latched port address
- o_busy  out  1  high while state != IDLE
- o_timeout  out  1  sticky stuck-cycle flag

Behaviour:
- Reset (async, i_reset high):
  - state=IDLE, o_addr=8'h00, latched device=0, latched hit=0, latched dir=read, timeout counter=0.
  - o_timeout=0, o_cs_n=4'hF, strobes=0, o_busy=0.
- Decode:
  - slot n matches when (i_addr & DEV_MASK) == (DEVn_BASE & DEV_MASK).
  - Lowest index wins on overlap.
  - Miss: hit=0, device=2'b00.
- o_device/o_hit:
  - In IDLE: combinational decode of i_addr, so the waitstate generator sees the correct slot in the first IORQ-low clock.
  - Otherwise: the latched values.
- States:
  - IDLE:
    - i_iorq_n=0 and i_m1_n=1 -> latch i_addr, device, hit, dir (write if i_wr_n=0, else read); go ACTIVE.
    - i_iorq_n=0 with i_m1_n=0 (interrupt acknowledge) is ignored; remain IDLE (see optional feature).
  - ACTIVE:
    - i_iorq_n=1 -> IDLE, no strobe (aborted cycle).
    - Else if i_wait=0 and the matching line is low (i_rd_n for read, i_wr_n for write) -> pulse o_rd_stb or o_wr_stb for one clock, only when latched hit=1; go DONE.
    - A miss still goes to DONE, with no strobe.
  - DONE: i_iorq_n=1 -> IDLE. No further strobes regardless of RD/WR activity.
- o_cs_n[n]: low only when state is ACTIVE or DONE, latched hit=1 and latched device=n; all others high.
- Strobes are registered outputs asserted in the clock after the qualifying condition; at most one per IORQ assertion.
- Timeout:
  - Counter clears in IDLE and increments each clock in ACTIVE/DONE, saturating at TIMEOUT.
  - Reaching TIMEOUT sets o_timeout.
  - i_timeout_clr clears o_timeout; set wins over clear in the same clock.
- Back-to-back cycles: IORQ high for a single clock returns to IDLE; the next low sample starts a fresh cycle.

Optional Feature:
- Macro: Z80_IO_DECODER_INTACK_EN.
- Defined:
  - Adds output o_inta (1 bit, reset 0).
  - IDLE with i_iorq_n=0 and i_m1_n=0 enters state INTA. In INTA:
    - o_inta=1, o_busy=1, o_cs_n=4'hF, no strobes.
    - The timeout counter runs.
    - Returns to IDLE when i_iorq_n=1.
- Undefined: the port does not exist, and interrupt-acknowledge cycles are ignored in IDLE as stated above.

Test Plan:
- Read from port 8'h25, i_wait low throughout:
  - o_device=2 combinationally on the first IORQ-low clock.
  - o_cs_n=4'b1011 from the next clock.
  - Exactly one o_rd_stb pulse.
  - o_addr=8'h25.
  - IDLE one clock after IORQ rises.
- Write to 8'h13 with i_wait high for 3 clocks:
  - No strobe while waiting.
  - o_wr_stb one clock after i_wait falls.
  - o_cs_n=4'b1101.
- Access to 8'h80 (miss): o_hit=0, o_cs_n=4'hF, no strobes, o_busy high until IORQ rises.
- IORQ held low with i_wait=1 for 64 clocks:
  - o_timeout=1 and stays set.
  - i_timeout_clr pulse clears it only after the cycle ends; clr asserted on the set clock leaves it 1.
- i_reset asserted mid-ACTIVE: all outputs return to reset values immediately, and no strobe follows release while IORQ stays low in an M1 cycle.
- IORQ and M1 both low:
  - Without the macro: o_busy stays 0.
  - With Z80_IO_DECODER_INTACK_EN: o_inta=1 until IORQ rises.
